datapath_core: RTL and testbench

Parametrised multi-cycle datapath: register file, ALU and write-back mux under a small control FSM.
Accepts one instruction at a time over a valid/ready handshake. Executes it in a fixed READ/EXEC/WRITE sequence and reports the result with registered flags.
Sits between the board switch/key decoder (instruction source) and the hex display drivers (result and debug outputs).

---
 rtl/datapath_pkg.sv | 18 +
 rtl/reg_file_nrw.sv | 36 +++
 rtl/datapath_core.sv | 148 ++++++++++++++
 tb/tb_datapath_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared opcode and FSM state encodings for datapath_core.
package datapath_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_LI  = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/reg_file_nrw.sv
// Register file: 3 combinational read ports (rs, rt, dbg), 1 synchronous write port.
// Register 0 reads as zero and ignores writes; no read-during-write bypass.
module reg_file_nrw #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [ADDR_WIDTH-1:0] rt_addr_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] rs_data_o,
  output logic [DATA_WIDTH-1:0] rt_data_o,
  output logic [DATA_WIDTH-1:0] dbg_data_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs_data_o  = (rs_addr_i  == '0) ? '0 : regs_q[rs_addr_i];
  assign rt_data_o  = (rt_addr_i  == '0) ? '0 : regs_q[rt_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/datapath_core.sv
// Multi-cycle datapath: IDLE accept -> READ operands -> EXEC ALU -> WRITE back, done in WRITE.
// One instruction per 4 cycles; instr_ready only in IDLE, other valids are dropped.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OP_WIDTH-1:0]   instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs,
  input  logic [ADDR_WIDTH-1:0] instr_rt,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_ovf,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [1:0]            state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rs_q, rt_q;
  logic [DATA_WIDTH-1:0] imm_q, opa_q, opb_q, result_q;
  logic                  zero_q, carry_q, ovf_q;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  logic [DATA_WIDTH+1:0] alu_out;

  // Packs {ovf, carry, result}.
  function automatic logic [DATA_WIDTH+1:0] alu_f(
    input logic [OP_WIDTH-1:0]   op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] imm
  );
    logic [DATA_WIDTH:0]   sum, dif;
    logic [DATA_WIDTH-1:0] res;
    logic                  c, v;
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[MSB:0];
        c   = sum[DATA_WIDTH];
        v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res = dif[MSB:0];
        c   = dif[DATA_WIDTH];
        v   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = DATA_WIDTH'($signed(a) < $signed(b));
      OP_LI:   res = imm;
      OP_MOV:  res = a;
      default: res = '0;
    endcase
    return {v, c, res};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (instr_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign alu_out = alu_f(op_q, opa_q, opb_q, imm_q);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs_q  <= instr_rs;
        rt_q  <= instr_rt;
        imm_q <= instr_imm;
      end
      if (state_q == ST_READ) begin
        opa_q <= rs_data;
        opb_q <= rt_data;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_out[MSB:0];
        carry_q  <= alu_out[DATA_WIDTH];
        ovf_q    <= alu_out[DATA_WIDTH+1];
        zero_q   <= (alu_out[MSB:0] == '0);
      end
    end
  end

  reg_file_nrw #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rf (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET),
    .rs_addr_i  (rs_q),
    .rt_addr_i  (rt_q),
    .dbg_addr_i (dbg_addr),
    .rs_data_o  (rs_data),
    .rt_data_o  (rt_data),
    .dbg_data_o (dbg_data),
    .we_i       (state_q == ST_WRITE),
    .wr_addr_i  (rd_q),
    .wr_data_i  (result_q)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_WRITE);
  assign result      = result_q;
  assign flag_zero   = zero_q;
  assign flag_carry  = carry_q;
  assign flag_ovf    = ovf_q;

endmodule

// File: tb/tb_datapath_core.sv
// Directed and random instruction sequences checked against an arithmetic model of the register file and ALU.
module tb_datapath_core;

  localparam int DW   = 4;
  localparam int AW   = 3;
  localparam int MOD  = 1 << DW;
  localparam int HALF = 1 << (DW - 1);

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs, instr_rt, dbg_addr;
  logic [DW-1:0] instr_imm, result, dbg_data;
  logic          done, flag_zero, flag_carry, flag_ovf;

  int pass_cnt = 0;
  int total    = 0;
  int rf [8];

  datapath_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_rd   (instr_rd),
    .instr_rs   (instr_rs),
    .instr_rt   (instr_rt),
    .instr_imm  (instr_imm),
    .result     (result),
    .done       (done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Reference ALU in plain integer arithmetic.
  task automatic ref_alu(input int op, input int a, input int b, input int imm,
                         output int res, output int c, output int v);
    int s;
    c = 0;
    v = 0;
    case (op)
      0: begin s = a + b; res = s % MOD; c = int'(s >= MOD);
               s = sgn(a) + sgn(b); v = int'(s >= HALF || s < -HALF); end
      1: begin res = (a - b + MOD) % MOD; c = int'(a < b);
               s = sgn(a) - sgn(b); v = int'(s >= HALF || s < -HALF); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = int'(sgn(a) < sgn(b));
      6: res = imm;
      default: res = a;
    endcase
  endtask

  task automatic issue(input int op, input int rd, input int rs, input int rt, input int imm);
    int res, c, v, waited;
    ref_alu(op, rf[rs], rf[rt], imm, res, c, v);
    @(negedge CLOCK_50);
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge CLOCK_50);
      waited++;
    end
    chk("ready_before_issue", 32'(instr_ready), 1);
    instr_op    = 3'(op);
    instr_rd    = AW'(rd);
    instr_rs    = AW'(rs);
    instr_rt    = AW'(rt);
    instr_imm   = DW'(imm);
    instr_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLOCK_50);
      chk("ready_busy", 32'(instr_ready), 0);
      chk("done_timing", 32'(done), 32'(k == 3));
    end
    chk("result", 32'(result), res);
    chk("zero", 32'(flag_zero), 32'(res == 0));
    chk("carry", 32'(flag_carry), c);
    chk("ovf", 32'(flag_ovf), v);
    if (rd != 0) rf[rd] = res;
    @(negedge CLOCK_50);
    chk("ready_after", 32'(instr_ready), 1);
    chk("done_after", 32'(done), 0);
    dbg_addr = AW'(rd);
    #1 chk("dbg_rd", 32'(dbg_data), rf[rd]);
  endtask

  task automatic sweep_regs();
    for (int r = 0; r < 8; r++) begin
      dbg_addr = AW'(r);
      #1 chk("dbg_sweep", 32'(dbg_data), rf[r]);
    end
  endtask

  initial begin
    int bb_op [3], bb_rd [3], bb_rs [3], bb_rt [3], bb_imm [3];
    int exp_res [3];
    int res, c, v, idx, ndone, acc_cycle;

    RESET = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs = '0; instr_rt = '0; instr_imm = '0; dbg_addr = '0;
    for (int r = 0; r < 8; r++) rf[r] = 0;
    repeat (3) @(posedge CLOCK_50);
    #1 RESET = 1'b0;

    // Reset state
    @(negedge CLOCK_50);
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'({flag_zero, flag_carry, flag_ovf}), 0);
    sweep_regs();

    // Directed sequence
    issue(6, 1, 0, 0, 9);     // LI R1,#9
    issue(6, 2, 0, 0, 7);     // LI R2,#7
    issue(0, 3, 1, 2, 0);     // ADD R3,R1,R2 -> 0, carry
    issue(1, 4, 2, 1, 0);     // SUB R4,R2,R1 -> 0xE, borrow
    issue(5, 5, 1, 2, 0);     // SLT R5,R1,R2 -> 1
    issue(6, 0, 0, 0, 5);     // LI R0,#5 discarded
    issue(7, 6, 0, 0, 0);     // MOV R6,R0 -> 0
    chk("r3_value", 32'(rf[3]), 0);
    chk("r4_value", 32'(rf[4]), 14);
    sweep_regs();

    // Reset asserted in the EXEC cycle of ADD R3,R1,R2
    @(negedge CLOCK_50);
    instr_op = 3'd0; instr_rd = 3'd3; instr_rs = 3'd1; instr_rt = 3'd2;
    instr_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 instr_valid = 1'b0;
    @(negedge CLOCK_50);      // READ
    @(negedge CLOCK_50);      // EXEC
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1 RESET = 1'b0;
    for (int r = 0; r < 8; r++) rf[r] = 0;
    @(negedge CLOCK_50);
    chk("exec_rst_ready", 32'(instr_ready), 1);
    chk("exec_rst_done", 32'(done), 0);
    chk("exec_rst_result", 32'(result), 0);
    chk("exec_rst_flags", 32'({flag_zero, flag_carry, flag_ovf}), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      chk("exec_rst_no_done", 32'(done), 0);
    end
    sweep_regs();

    // Back-to-back with instr_valid held high; RAW chain R1 -> R2 -> R3
    bb_op[0] = 6; bb_rd[0] = 1; bb_rs[0] = 0; bb_rt[0] = 0; bb_imm[0] = int'($urandom_range(1, MOD - 1));
    bb_op[1] = 0; bb_rd[1] = 2; bb_rs[1] = 1; bb_rt[1] = 1; bb_imm[1] = 0;
    bb_op[2] = 1; bb_rd[2] = 3; bb_rs[2] = 2; bb_rt[2] = 1; bb_imm[2] = 0;
    for (int i = 0; i < 3; i++) begin
      ref_alu(bb_op[i], rf[bb_rs[i]], rf[bb_rt[i]], bb_imm[i], res, c, v);
      exp_res[i] = res;
      rf[bb_rd[i]] = res;
    end
    idx = 0; ndone = 0; acc_cycle = 0;
    instr_op = 3'(bb_op[0]); instr_rd = AW'(bb_rd[0]); instr_rs = AW'(bb_rs[0]);
    instr_rt = AW'(bb_rt[0]); instr_imm = DW'(bb_imm[0]);
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLOCK_50);
      chk("bb_ready_pattern", 32'(instr_ready), 32'(cyc % 4 == 0));
      chk("bb_done_pattern", 32'(done), 32'(cyc % 4 == 3));
      if (done) begin
        chk("bb_result", 32'(result), exp_res[ndone < 3 ? ndone : 2]);
        ndone++;
      end
      acc_cycle = int'(instr_ready && instr_valid);
      @(posedge CLOCK_50);
      #1;
      if (acc_cycle != 0) begin
        idx++;
        if (idx < 3) begin
          instr_op = 3'(bb_op[idx]); instr_rd = AW'(bb_rd[idx]); instr_rs = AW'(bb_rs[idx]);
          instr_rt = AW'(bb_rt[idx]); instr_imm = DW'(bb_imm[idx]);
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    instr_valid = 1'b0;
    chk("bb_done_count", 32'(ndone), 3);
    sweep_regs();

    // Random instructions
    for (int n = 0; n < 40; n++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)));
    end
    sweep_regs();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
